// File: rtl/music_sequencer.sv
// Note sequencer feeding the tone generator: walks a synchronous song ROM, holds
// each note for a tempo-controlled cycle count, with play/pause, reverse and tempo.
`timescale 1ns/1ps
module music_sequencer #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned NOTE_CYCLES = 31_250_000,
   parameter int unsigned TEMPO_STEP  = 1_000_000,
   parameter int unsigned MIN_CYCLES  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  play_pause,
   input  logic                  reverse,
   input  logic                  tempo_up,
   input  logic                  tempo_down,
   input  logic [ADDR_WIDTH-1:0] last_addr,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [23:0]           rom_data,
   output logic [23:0]           tone_period,
   output logic                  output_enable,
   output logic                  playing
);

   localparam int unsigned LEN_W  = 32;
   localparam int unsigned TONE_W = 24;
   localparam int unsigned EXT_W  = LEN_W + 1;

   localparam logic [ADDR_WIDTH-1:0] A_ONE   = ADDR_WIDTH'(1);
   localparam logic [LEN_W-1:0]      LEN_RST = LEN_W'(NOTE_CYCLES);
   localparam logic [LEN_W-1:0]      LEN_MIN = LEN_W'(MIN_CYCLES);
   localparam logic [LEN_W-1:0]      LEN_ONE = LEN_W'(1);
   localparam logic [EXT_W-1:0]      STEP_X  = EXT_W'(TEMPO_STEP);
   localparam logic [EXT_W-1:0]      MIN_X   = EXT_W'(MIN_CYCLES);
   localparam logic [EXT_W-1:0]      MAX_X   = {1'b0, {LEN_W{1'b1}}};

   typedef enum logic [1:0] {
      S_PAUSED  = 2'd0,
      S_FETCH_A = 2'd1,
      S_FETCH_D = 2'd2,
      S_PLAY    = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
   logic [TONE_W-1:0]     tone_q, tone_d;
   logic                  oe_q, oe_d;
   logic                  playing_q, playing_d;
   logic                  dir_q, dir_d;
   logic                  pend_q, pend_d;
   logic [LEN_W-1:0]      note_len_q, note_len_d;
   logic [LEN_W-1:0]      remain_q, remain_d;
   logic [ADDR_WIDTH-1:0] addr_adv_c;
   logic [EXT_W-1:0]      len_dec_c, len_inc_c;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_PAUSED;
      else      state_q <= state_d;
   end

   // Next-state logic; a pause pulse has priority over note end
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_PAUSED:  if (play_pause) state_d = (remain_q != '0) ? S_PLAY : S_FETCH_A;
         S_FETCH_A: state_d = S_FETCH_D;
         S_FETCH_D: state_d = (pend_q || play_pause) ? S_PAUSED : S_PLAY;
         S_PLAY: begin
            if (play_pause)             state_d = S_PAUSED;
            else if (remain_q <= LEN_ONE) state_d = S_FETCH_A;
         end
         default:   state_d = S_PAUSED;
      endcase
   end

   // Next song address in the current direction, wrapping at 0 / last_addr
   always_comb begin
      addr_adv_c = rom_addr_q + A_ONE;
      if (dir_q)                         addr_adv_c = (rom_addr_q == '0) ? last_addr : rom_addr_q - A_ONE;
      else if (rom_addr_q == last_addr)  addr_adv_c = '0;
   end

   // Tempo: saturating add/subtract, simultaneous pulses cancel
   always_comb begin
      len_dec_c  = {1'b0, note_len_q} - STEP_X;
      len_inc_c  = {1'b0, note_len_q} + STEP_X;
      note_len_d = note_len_q;
      if (tempo_up && !tempo_down)
         note_len_d = ({1'b0, note_len_q} < (MIN_X + STEP_X)) ? LEN_MIN : len_dec_c[LEN_W-1:0];
      else if (tempo_down && !tempo_up)
         note_len_d = (len_inc_c > MAX_X) ? {LEN_W{1'b1}} : len_inc_c[LEN_W-1:0];
   end

   // Output / datapath next values
   always_comb begin
      rom_addr_d = rom_addr_q;
      tone_d     = tone_q;
      remain_d   = remain_q;
      pend_d     = pend_q;
      dir_d      = dir_q ^ reverse;
      case (state_q)
         S_FETCH_A: if (play_pause) pend_d = 1'b1;
         S_FETCH_D: begin
            tone_d   = rom_data;
            remain_d = note_len_q;
            pend_d   = 1'b0;
         end
         S_PLAY: begin
            if (!play_pause) begin
               if (remain_q <= LEN_ONE) begin
                  rom_addr_d = addr_adv_c;
                  remain_d   = '0;
               end else begin
                  remain_d = remain_q - LEN_ONE;
               end
            end
         end
         default: ;
      endcase
      // Enable holds across the fetch cycles so consecutive notes have no gap
      case (state_d)
         S_PAUSED: oe_d = 1'b0;
         S_PLAY:   oe_d = (tone_d != '0);
         default:  oe_d = oe_q;
      endcase
      playing_d = (state_d != S_PAUSED);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rom_addr_q <= '0;
         tone_q     <= '0;
         oe_q       <= 1'b0;
         playing_q  <= 1'b0;
         dir_q      <= 1'b0;
         pend_q     <= 1'b0;
         note_len_q <= LEN_RST;
         remain_q   <= '0;
      end else begin
         rom_addr_q <= rom_addr_d;
         tone_q     <= tone_d;
         oe_q       <= oe_d;
         playing_q  <= playing_d;
         dir_q      <= dir_d;
         pend_q     <= pend_d;
         note_len_q <= note_len_d;
         remain_q   <= remain_d;
      end
   end

   assign rom_addr      = rom_addr_q;
   assign tone_period   = tone_q;
   assign output_enable = oe_q;
   assign playing       = playing_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Bench for music_sequencer: directed scenarios with literal expectations plus
// randomized pulses, all checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_music_sequencer;

   localparam int unsigned AW   = 10;
   localparam int          NC   = 8;
   localparam int          TS   = 2;
   localparam int          MC   = 4;
   localparam int          LAST = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          play_pause, reverse, tempo_up, tempo_down;
   logic [AW-1:0] last_addr;
   logic [AW-1:0] rom_addr;
   logic [23:0]   rom_data;
   logic [23:0]   tone_period;
   logic          output_enable, playing;

   logic [23:0] rom [0:15];
   int checks = 0;
   int errors = 0;

   music_sequencer #(
      .ADDR_WIDTH(AW), .NOTE_CYCLES(NC), .TEMPO_STEP(TS), .MIN_CYCLES(MC)
   ) dut (
      .clk(clk), .rst(rst), .play_pause(play_pause), .reverse(reverse),
      .tempo_up(tempo_up), .tempo_down(tempo_down), .last_addr(last_addr),
      .rom_addr(rom_addr), .rom_data(rom_data), .tone_period(tone_period),
      .output_enable(output_enable), .playing(playing)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 16; i++) rom[i] = 24'd0;
      rom[0] = 24'd100; rom[1] = 24'd200; rom[2] = 24'd0; rom[3] = 24'd400;
   end

   always @(posedge clk) rom_data <= rom[rom_addr[3:0]];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Behavioural model: the song as a list, a note as a countdown, a fetch as a
   // two-cycle delay before the new tone is heard.
   bit          m_paused, m_dir, m_pend, m_oe;
   int          m_fetch, m_addr;
   longint      m_remain, m_len;
   logic [23:0] m_tone;

   task automatic model_reset();
      m_paused = 1; m_dir = 0; m_pend = 0; m_oe = 0;
      m_fetch = 0; m_addr = 0; m_remain = 0; m_len = NC; m_tone = 24'd0;
   endtask

   task automatic model_step();
      longint nl;
      nl = m_len;
      if (tempo_up && !tempo_down) begin
         nl = nl - TS;
         if (nl < MC) nl = MC;
      end else if (tempo_down && !tempo_up) begin
         nl = nl + TS;
         if (nl > 64'hFFFF_FFFF) nl = 64'hFFFF_FFFF;
      end
      if (m_paused) begin
         if (play_pause) begin
            m_paused = 0;
            if (m_remain != 0) begin m_fetch = 0; m_oe = (m_tone != 0); end
            else m_fetch = 2;
         end
      end else if (m_fetch == 2) begin
         if (play_pause) m_pend = 1;
         m_fetch = 1;
      end else if (m_fetch == 1) begin
         m_tone   = rom[m_addr];
         m_remain = m_len;
         m_fetch  = 0;
         if (m_pend || play_pause) begin m_pend = 0; m_paused = 1; m_oe = 0; end
         else m_oe = (m_tone != 0);
      end else begin
         if (play_pause) begin
            m_paused = 1; m_oe = 0;
         end else if (m_remain == 1) begin
            if (!m_dir) m_addr = (m_addr == LAST) ? 0 : m_addr + 1;
            else        m_addr = (m_addr == 0) ? LAST : m_addr - 1;
            m_remain = 0;
            m_fetch  = 2;
         end else begin
            m_remain = m_remain - 1;
         end
      end
      if (reverse) m_dir = ~m_dir;
      m_len = nl;
   endtask

   // Per-cycle comparison against the model
   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         if (!rst) model_reset();
         else      model_step();
         #1;
         chk("rom_addr", rom_addr, m_addr);
         chk("tone_period", tone_period, m_tone);
         chk("output_enable", output_enable, m_oe);
         chk("playing", playing, !m_paused);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic pulse_pp();
      play_pause = 1'b1; cyc(1); play_pause = 1'b0;
   endtask

   task automatic pulse_rv();
      reverse = 1'b1; cyc(1); reverse = 1'b0;
   endtask

   initial begin
      logic [23:0] exp_t [0:4];
      logic        exp_o [0:4];
      exp_t[0] = 24'd100; exp_t[1] = 24'd200; exp_t[2] = 24'd0; exp_t[3] = 24'd400; exp_t[4] = 24'd100;
      exp_o[0] = 1'b1; exp_o[1] = 1'b1; exp_o[2] = 1'b0; exp_o[3] = 1'b1; exp_o[4] = 1'b1;
      rst = 1'b0; play_pause = 1'b0; reverse = 1'b0; tempo_up = 1'b0; tempo_down = 1'b0;
      last_addr = AW'(LAST);
      cyc(2);
      chk("lit_rst_addr", rom_addr, 0);
      chk("lit_rst_tone", tone_period, 0);
      chk("lit_rst_oe", output_enable, 0);
      chk("lit_rst_playing", playing, 0);
      rst = 1'b1;

      // Forward playback: five notes, 10 cycles apart
      pulse_pp();
      cyc(2);
      for (int n = 0; n < 5; n++) begin
         chk("lit_seq_tone", tone_period, exp_t[n]);
         chk("lit_seq_oe", output_enable, exp_o[n]);
         cyc(10);
      end

      // Reverse during note 400, then wrap through address 0
      cyc(20);
      chk("lit_at_400", tone_period, 400);
      pulse_rv();
      cyc(9);
      chk("lit_rev_rest_tone", tone_period, 0);
      chk("lit_rev_rest_oe", output_enable, 0);
      chk("lit_rev_rest_addr", rom_addr, 2);
      cyc(10);
      chk("lit_rev_200", tone_period, 200);
      cyc(10);
      chk("lit_rev_100", tone_period, 100);
      cyc(10);
      chk("lit_rev_wrap_400", tone_period, 400);
      chk("lit_rev_wrap_addr", rom_addr, 3);

      // Pause with remain=3, hold 20 cycles, resume
      cyc(5);
      pulse_pp();
      chk("lit_pause_playing", playing, 0);
      chk("lit_pause_oe", output_enable, 0);
      cyc(20);
      chk("lit_paused_oe", output_enable, 0);
      chk("lit_paused_tone", tone_period, 400);
      pulse_pp();
      chk("lit_resume_oe", output_enable, 1);
      cyc(2);
      chk("lit_resume_addr_hold", rom_addr, 3);
      cyc(1);
      chk("lit_resume_addr_adv", rom_addr, 2);

      // Pause during FETCH_D: note loads, then paused with a full note pending
      cyc(1);
      pulse_pp();
      chk("lit_fd_playing", playing, 0);
      chk("lit_fd_tone", tone_period, 0);
      cyc(3);
      pulse_pp();
      cyc(7);
      chk("lit_fd_len_hold", rom_addr, 2);
      cyc(1);
      chk("lit_fd_len_adv", rom_addr, 1);

      // Tempo: three ups saturate at 4, up+down together changes nothing
      cyc(2);
      tempo_up = 1'b1;
      cyc(3);
      tempo_down = 1'b1;
      cyc(1);
      tempo_up = 1'b0; tempo_down = 1'b0;
      cyc(3);
      chk("lit_tempo_cur_hold", rom_addr, 1);
      cyc(1);
      chk("lit_tempo_cur_adv", rom_addr, 0);
      cyc(5);
      chk("lit_tempo_new_hold", rom_addr, 0);
      cyc(1);
      chk("lit_tempo_new_adv", rom_addr, 3);

      // Randomized pulses, with occasional resets
      for (int i = 0; i < 3000; i++) begin
         play_pause = ($urandom_range(15) == 0);
         reverse    = ($urandom_range(15) == 0);
         tempo_up   = ($urandom_range(9) == 0);
         tempo_down = ($urandom_range(9) == 0);
         rst        = ($urandom_range(599) != 0);
         cyc(1);
      end
      play_pause = 1'b0; reverse = 1'b0; tempo_up = 1'b0; tempo_down = 1'b0;

      // Reset mid-PLAY at address 2, then restart from the first entry
      rst = 1'b0;
      cyc(1);
      rst = 1'b1;
      pulse_pp();
      cyc(2);
      chk("lit_restart_tone", tone_period, 100);
      cyc(23);
      chk("lit_mid_addr2", rom_addr, 2);
      chk("lit_mid_playing", playing, 1);
      rst = 1'b0;
      #1;
      chk("lit_async_oe", output_enable, 0);
      chk("lit_async_tone", tone_period, 0);
      chk("lit_async_addr", rom_addr, 0);
      chk("lit_async_playing", playing, 0);
      cyc(1);
      rst = 1'b1;
      pulse_pp();
      cyc(2);
      chk("lit_after_rst_tone", tone_period, 100);
      chk("lit_after_rst_oe", output_enable, 1);
      chk("lit_after_rst_addr", rom_addr, 0);
      cyc(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
